interboard_tx_scheduler: RTL and testbench

INTERBOARD_TX_SCHEDULER -- requirements
Module: interboard_tx_scheduler

---
 rtl/interboard_tx_scheduler.sv | 270 +++++++++++++++++++++++++++
 tb/tb_interboard_tx_scheduler.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/interboard_tx_scheduler.sv
// rtl/interboard_tx_scheduler.sv - strict-priority message scheduler feeding the interboard link sender
//
// Purpose:
//   Queues control messages in a 4-entry FIFO and table-reset/start-game
//   messages in a 1-entry priority slot. Launches one message at a time to
//   the link sender, waits for the sender to accept it (send_ready falling)
//   and then to finish it (send_ready rising). A message the sender never
//   accepts is relaunched MAX_RETRY times and then dropped with tx_err.
//
// Ports:
//   clk            system clock, rising edge
//   rst            synchronous active-high reset
//   interboard_rst synchronous active-high clear from the peer board
//   ctrl_transmit  one-cycle request to enqueue ctrl_msg into the FIFO
//   ctrl_msg       23-bit packed control message
//   prio_transmit  one-cycle request to post prio_msg into the priority slot
//   prio_msg       23-bit packed priority message
//   send_ready     link sender idle
//   transmit       one-cycle launch pulse to the sender
//   tx_msg         message presented to the sender, stable while in flight
//   q_full         ctrl FIFO holds 4 entries
//   q_cnt          ctrl FIFO occupancy 0..4
//   tx_err         one-cycle pulse when a message is dropped after retries
//   drop_cnt       (INTERBOARD_TX_DROPCNT_EN only) saturating count of
//                  discarded FIFO pushes plus tx_err events
//
// Configuration macro: INTERBOARD_TX_DROPCNT_EN

module interboard_tx_scheduler #(
    parameter int ACCEPT_TIMEOUT = 255,
    parameter int MAX_RETRY      = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        interboard_rst,
    input  logic        ctrl_transmit,
    input  logic [22:0] ctrl_msg,
    input  logic        prio_transmit,
    input  logic [22:0] prio_msg,
    input  logic        send_ready,
    output logic        transmit,
    output logic [22:0] tx_msg,
    output logic        q_full,
    output logic [2:0]  q_cnt,
`ifdef INTERBOARD_TX_DROPCNT_EN
    output logic        tx_err,
    output logic [7:0]  drop_cnt
`else
    output logic        tx_err
`endif
);

    localparam int TW = (ACCEPT_TIMEOUT < 2) ? 1 : $clog2(ACCEPT_TIMEOUT + 1);
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    // transmit is registered out of LAUNCH, so the first WAIT_ACCEPT cycle
    // already has the pulse on the wire; ending on ACCEPT_TIMEOUT-1 makes
    // consecutive launch pulses exactly ACCEPT_TIMEOUT+1 cycles apart.
    localparam logic [TW-1:0] TIMER_LAST = TW'(ACCEPT_TIMEOUT - 1);
    localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY);

    typedef enum logic [1:0] {
        S_IDLE        = 2'd0,
        S_LAUNCH      = 2'd1,
        S_WAIT_ACCEPT = 2'd2,
        S_WAIT_DONE   = 2'd3
    } state_e;

    state_e          state_q, state_d;

    logic [22:0]     fifo_mem_q [4];
    logic [1:0]      wr_ptr_q, rd_ptr_q;
    logic [2:0]      cnt_q, cnt_d;

    logic            prio_valid_q, prio_valid_d;
    logic [22:0]     prio_msg_q;

    logic            sel_prio_q;
    logic [22:0]     tx_msg_q;
    logic [TW-1:0]   timer_q;
    logic [RW-1:0]   retry_q;
    logic            transmit_q;
    logic            tx_err_q;

    logic            clr;
    logic            any_valid;
    logic            timeout;
    logic            retry_max;

    // FSM strobes
    logic            select_s;
    logic            launch_s;
    logic            done_s;
    logic            drop_s;
    logic            retry_inc_s;

    logic            pop_s, pop_fifo, pop_prio;
    logic            fifo_full;
    logic            push_ok, push_drop;
    logic            prio_busy, prio_load;

    assign clr       = rst | interboard_rst;
    assign any_valid = prio_valid_q | (cnt_q != 3'd0);
    assign timeout   = (timer_q == TIMER_LAST);
    assign retry_max = (retry_q == RETRY_LAST);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (send_ready && any_valid) begin
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                state_d = S_WAIT_ACCEPT;
            end
            S_WAIT_ACCEPT: begin
                // Acceptance wins over a timeout landing in the same cycle.
                if (!send_ready) begin
                    state_d = S_WAIT_DONE;
                end else if (timeout) begin
                    state_d = retry_max ? S_IDLE : S_LAUNCH;
                end
            end
            S_WAIT_DONE: begin
                if (send_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs / strobes ----------------
    always_comb begin
        select_s    = 1'b0;
        launch_s    = 1'b0;
        done_s      = 1'b0;
        drop_s      = 1'b0;
        retry_inc_s = 1'b0;
        case (state_q)
            S_IDLE:        select_s = send_ready & any_valid;
            S_LAUNCH:      launch_s = 1'b1;
            S_WAIT_ACCEPT: begin
                drop_s      = send_ready & timeout & retry_max;
                retry_inc_s = send_ready & timeout & ~retry_max;
            end
            S_WAIT_DONE:   done_s = send_ready;
            default: ;
        endcase
    end

    // The selected entry stays in its source until it completes or is
    // dropped; only then is it popped.
    assign pop_s    = done_s | drop_s;
    assign pop_fifo = pop_s & ~sel_prio_q;
    assign pop_prio = pop_s & sel_prio_q;

    assign fifo_full = (cnt_q == 3'd4);
    assign push_ok   = ctrl_transmit & (~fifo_full | pop_fifo);
    assign push_drop = ctrl_transmit & ~push_ok;
    assign cnt_d     = cnt_q + {2'b00, push_ok} - {2'b00, pop_fifo};

    // The slot is busy from the selecting cycle until its pop; a prio post
    // in that window is discarded, except in the pop cycle itself where the
    // new message simply replaces the completed one.
    assign prio_busy = ((state_q != S_IDLE) & sel_prio_q) | (select_s & prio_valid_q);
    assign prio_load = prio_transmit & (~prio_busy | pop_prio);

    always_comb begin
        prio_valid_d = prio_valid_q;
        if (prio_load) begin
            prio_valid_d = 1'b1;
        end else if (pop_prio) begin
            prio_valid_d = 1'b0;
        end
    end

    // FIFO storage carries no reset; occupancy and pointers qualify it.
    always_ff @(posedge clk) begin
        if (!clr && push_ok) begin
            fifo_mem_q[wr_ptr_q] <= ctrl_msg;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            wr_ptr_q     <= 2'd0;
            rd_ptr_q     <= 2'd0;
            cnt_q        <= 3'd0;
            prio_valid_q <= 1'b0;
            prio_msg_q   <= 23'd0;
            sel_prio_q   <= 1'b0;
            tx_msg_q     <= 23'd0;
            timer_q      <= '0;
            retry_q      <= '0;
            transmit_q   <= 1'b0;
            tx_err_q     <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 2'd1;
            end
            if (pop_fifo) begin
                rd_ptr_q <= rd_ptr_q + 2'd1;
            end
            cnt_q        <= cnt_d;
            prio_valid_q <= prio_valid_d;
            if (prio_load) begin
                prio_msg_q <= prio_msg;
            end

            if (select_s) begin
                sel_prio_q <= prio_valid_q;
                tx_msg_q   <= prio_valid_q ? prio_msg_q : fifo_mem_q[rd_ptr_q];
            end

            if (launch_s) begin
                timer_q <= '0;
            end else if ((state_q == S_WAIT_ACCEPT) && !timeout) begin
                timer_q <= timer_q + TW'(1);
            end

            if (retry_inc_s) begin
                retry_q <= retry_q + RW'(1);
            end else if (pop_s) begin
                retry_q <= '0;
            end

            transmit_q <= launch_s;
            tx_err_q   <= drop_s;
        end
    end

    assign transmit = transmit_q;
    assign tx_msg   = tx_msg_q;
    assign q_full   = fifo_full;
    assign q_cnt    = cnt_q;
    assign tx_err   = tx_err_q;

`ifdef INTERBOARD_TX_DROPCNT_EN
    logic [7:0] drop_cnt_q;
    logic [8:0] drop_sum;

    // A discarded push and a tx_err may coincide, so the step can be 2.
    assign drop_sum = {1'b0, drop_cnt_q} + {7'd0, push_drop} + {7'd0, drop_s};

    always_ff @(posedge clk) begin
        if (clr) begin
            drop_cnt_q <= 8'd0;
        end else if (drop_sum[8]) begin
            drop_cnt_q <= 8'hFF;
        end else begin
            drop_cnt_q <= drop_sum[7:0];
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_interboard_tx_scheduler.sv
// tb/tb_interboard_tx_scheduler.sv - scoreboard bench for interboard_tx_scheduler

module tb_interboard_tx_scheduler;

    localparam int T_ACC = 20;
    localparam int N_RTY = 3;

    logic        clk;
    logic        rst;
    logic        interboard_rst;
    logic        ctrl_transmit;
    logic [22:0] ctrl_msg;
    logic        prio_transmit;
    logic [22:0] prio_msg;
    logic        send_ready;
    logic        transmit;
    logic [22:0] tx_msg;
    logic        q_full;
    logic [2:0]  q_cnt;
    logic        tx_err;
`ifdef INTERBOARD_TX_DROPCNT_EN
    logic [7:0]  drop_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int tx_count = 0;
    int err_count = 0;
    int tx_cyc[$];
    logic [22:0] exp_q[$];

    // sender model controls
    logic hold_low;
    logic auto_ack;
    int   busy_len;
    int   busy_cnt;

    interboard_tx_scheduler #(
        .ACCEPT_TIMEOUT(T_ACC),
        .MAX_RETRY     (N_RTY)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .interboard_rst(interboard_rst),
        .ctrl_transmit (ctrl_transmit),
        .ctrl_msg      (ctrl_msg),
        .prio_transmit (prio_transmit),
        .prio_msg      (prio_msg),
        .send_ready    (send_ready),
        .transmit      (transmit),
        .tx_msg        (tx_msg),
        .q_full        (q_full),
        .q_cnt         (q_cnt),
`ifdef INTERBOARD_TX_DROPCNT_EN
        .tx_err        (tx_err),
        .drop_cnt      (drop_cnt)
`else
        .tx_err        (tx_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Sender: accepts a launch by dropping send_ready for busy_len cycles.
    initial begin
        send_ready = 1'b0;
        busy_cnt   = 0;
        forever begin
            @(negedge clk);
            if (busy_cnt > 0) busy_cnt--;
            if (transmit && auto_ack) busy_cnt = busy_len;
            send_ready = !hold_low && (busy_cnt == 0);
        end
    end

    // Scoreboard: every launch pulse must match the next expected message.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (transmit) begin
                e = (exp_q.size() > 0) ? 32'(exp_q.pop_front()) : 32'hDEADBEEF;
                check("tx_msg", 32'(tx_msg), e);
                tx_count++;
                tx_cyc.push_back(cyc);
            end
            if (tx_err) err_count++;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

    task automatic drain(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_tx(input int target, input int budget, input string tag);
        int n = 0;
        while (tx_count < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(tx_count), 32'(target));
    endtask

    initial begin
        int lat;
        int base;
        int e0;
        int n;

        rst = 1'b1; interboard_rst = 1'b0;
        ctrl_transmit = 1'b0; ctrl_msg = '0;
        prio_transmit = 1'b0; prio_msg = '0;
        hold_low = 1'b0; auto_ack = 1'b1; busy_len = 10;
        drain(3);
        check("rst_transmit", 32'(transmit), 32'd0);
        check("rst_tx_msg",   32'(tx_msg),   32'd0);
        check("rst_q_cnt",    32'(q_cnt),    32'd0);
        check("rst_q_full",   32'(q_full),   32'd0);
        check("rst_tx_err",   32'(tx_err),   32'd0);
        rst = 1'b0;
        drain(2);

        // single send with latency
        busy_len = 10;
        ctrl_msg = 23'h12345; ctrl_transmit = 1'b1; exp_q.push_back(23'h12345);
        @(negedge clk);
        ctrl_transmit = 1'b0;
        check("t1_q_cnt_push", 32'(q_cnt), 32'd1);
        lat = 0;
        while (!transmit && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check("t1_latency", 32'(lat), 32'd2);
        n = 0;
        while (q_cnt != 3'd0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("t1_q_cnt_done", 32'(q_cnt), 32'd0);
        drain(3);

        // simultaneous ctrl + prio
        busy_len = 3; base = tx_count;
        ctrl_msg = 23'h00001; ctrl_transmit = 1'b1;
        prio_msg = 23'h7FFFF; prio_transmit = 1'b1;
        exp_q.push_back(23'h7FFFF); exp_q.push_back(23'h00001);
        @(negedge clk);
        ctrl_transmit = 1'b0; prio_transmit = 1'b0;
        wait_tx(base + 2, 60, "t2_tx_count");
        drain(10);
        check("t2_q_cnt", 32'(q_cnt), 32'd0);
        check("t2_exp_left", 32'(exp_q.size()), 32'd0);

        // prio overwrite: newest wins
        hold_low = 1'b1; drain(2); base = tx_count;
        prio_msg = 23'h0AAAA; prio_transmit = 1'b1;
        @(negedge clk);
        prio_msg = 23'h05555;
        @(negedge clk);
        prio_transmit = 1'b0; exp_q.push_back(23'h05555);
        hold_low = 1'b0;
        wait_tx(base + 1, 40, "t3_tx_count");
        drain(10);
        check("t3_exp_left", 32'(exp_q.size()), 32'd0);
        check("t3_tx_count_final", 32'(tx_count), 32'(base + 1));

        // overflow
        hold_low = 1'b1; drain(2); base = tx_count;
        for (int i = 0; i < 5; i++) begin
            ctrl_msg = 23'h100 + 23'(i); ctrl_transmit = 1'b1;
            if (i < 4) exp_q.push_back(23'h100 + 23'(i));
            @(negedge clk);
        end
        ctrl_transmit = 1'b0;
        check("t4_q_full", 32'(q_full), 32'd1);
        check("t4_q_cnt",  32'(q_cnt),  32'd4);
`ifdef INTERBOARD_TX_DROPCNT_EN
        check("t4_drop_cnt", 32'(drop_cnt), 32'd1);
`endif
        hold_low = 1'b0;
        wait_tx(base + 4, 200, "t4_tx_count");
        drain(10);
        check("t4_q_cnt_done", 32'(q_cnt), 32'd0);
        check("t4_q_full_done", 32'(q_full), 32'd0);
        check("t4_exp_left", 32'(exp_q.size()), 32'd0);

        // accept timeout with retries
        auto_ack = 1'b0; drain(2);
        tx_cyc.delete(); e0 = err_count;
        ctrl_msg = 23'h2BEEF; ctrl_transmit = 1'b1;
        for (int i = 0; i <= N_RTY; i++) exp_q.push_back(23'h2BEEF);
        @(negedge clk);
        ctrl_transmit = 1'b0;
        n = 0;
        while (err_count == e0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("t5_tx_err", 32'(err_count), 32'(e0 + 1));
        check("t5_pulses", 32'(tx_cyc.size()), 32'(N_RTY + 1));
        for (int i = 0; i + 1 < tx_cyc.size(); i++)
            check("t5_spacing", 32'(tx_cyc[i+1] - tx_cyc[i]), 32'(T_ACC + 1));
        check("t5_q_cnt", 32'(q_cnt), 32'd0);
        check("t5_exp_left", 32'(exp_q.size()), 32'd0);
`ifdef INTERBOARD_TX_DROPCNT_EN
        check("t5_drop_cnt", 32'(drop_cnt), 32'd2);
`endif
        auto_ack = 1'b1;
        drain(5);

        // peer reset during WAIT_DONE with three queued, push in reset cycle
        busy_len = 20; hold_low = 1'b1; drain(2); base = tx_count;
        for (int i = 0; i < 3; i++) begin
            ctrl_msg = 23'h300 + 23'(i); ctrl_transmit = 1'b1;
            @(negedge clk);
        end
        ctrl_transmit = 1'b0;
        exp_q.push_back(23'h300);
        hold_low = 1'b0;
        wait_tx(base + 1, 20, "t6_first_tx");
        drain(5);
        check("t6_q_cnt_pre", 32'(q_cnt), 32'd3);
        interboard_rst = 1'b1; ctrl_msg = 23'h3FF; ctrl_transmit = 1'b1;
        @(negedge clk);
        interboard_rst = 1'b0; ctrl_transmit = 1'b0;
        check("t6_q_cnt",    32'(q_cnt),    32'd0);
        check("t6_transmit", 32'(transmit), 32'd0);
        check("t6_tx_msg",   32'(tx_msg),   32'd0);
        check("t6_q_full",   32'(q_full),   32'd0);
`ifdef INTERBOARD_TX_DROPCNT_EN
        check("t6_drop_cnt", 32'(drop_cnt), 32'd0);
`endif
        drain(60);
        check("t6_no_more_tx", 32'(tx_count), 32'(base + 1));
        check("t6_q_cnt_late", 32'(q_cnt), 32'd0);

        // ten back-to-back messages through the wrapping FIFO
        busy_len = 2; base = tx_count;
        for (int i = 0; i < 10; i++) begin
            n = 0;
            while (q_full && n < 100) begin
                @(negedge clk);
                n++;
            end
            ctrl_msg = 23'(i); ctrl_transmit = 1'b1; exp_q.push_back(23'(i));
            @(negedge clk);
            ctrl_transmit = 1'b0;
        end
        wait_tx(base + 10, 400, "t7_tx_count");
        drain(10);
        check("t7_exp_left", 32'(exp_q.size()), 32'd0);
        check("t7_q_cnt", 32'(q_cnt), 32'd0);

        check("total_tx_err", 32'(err_count), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
